// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, data SRAM req/resp handshake, load align/extend, store strobes.
// Latency: 1 cycle for non-memory ops, 3+ for SRAM ops. Holds its DONE result while mem_wb_reg_allow_in is low.
module mem_stage #(
    parameter int EX_W  = 107,
    parameter int MEM_W = 70
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_to_mem_reg_valid,
    input  logic [EX_W-1:0]  ex_data,
    output logic             ex_mem_reg_allow_in,
    output logic             data_sram_req,
    output logic             data_sram_wr,
    output logic [1:0]       data_sram_size,
    output logic [3:0]       data_sram_wstrb,
    output logic [31:0]      data_sram_addr,
    output logic [31:0]      data_sram_wdata,
    input  logic             data_sram_addr_ok,
    input  logic             data_sram_data_ok,
    input  logic [31:0]      data_sram_rdata,
    input  logic             mem_wb_reg_allow_in,
    output logic             mem_to_wb_reg_valid,
    output logic [MEM_W-1:0] mem_data,
    output logic             mem_misalign
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [1:0]  size;
        logic        uns;
    } ex_bundle_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    ex_bundle_t  w_ex;

    logic [31:0] r_pc;
    logic [31:0] r_alu;
    logic [31:0] r_sd;
    logic [4:0]  r_rd;
    logic        r_reg_we;
    logic        r_mem_re;
    logic        r_mem_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_misalign;
    logic [31:0] r_wb_wdata;

    logic        w_allow_in;
    logic        w_accept;
    logic        w_in_mem;
    logic        w_in_misalign;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_ext;
    logic        w_req;
    logic        w_wb_vld;
    logic        w_misalign_out;

    assign w_ex = ex_bundle_t'(ex_data);

    assign w_allow_in = (r_state == S_IDLE) ||
                        ((r_state == S_DONE) && mem_wb_reg_allow_in);
    assign w_accept   = ex_to_mem_reg_valid && w_allow_in;

    // Size 3 is treated like a word for both alignment and strobes.
    assign w_in_mem      = w_ex.mem_re | w_ex.mem_we;
    assign w_in_misalign = w_in_mem &&
                           (((w_ex.size == 2'd1) && w_ex.alu[0]) ||
                            (w_ex.size[1] && (w_ex.alu[1:0] != 2'b00)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_in_mem && !w_in_misalign) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (data_sram_addr_ok) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (mem_wb_reg_allow_in) begin
                    if (w_accept) begin
                        w_next = (w_in_mem && !w_in_misalign) ? S_REQ : S_DONE;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req          = (r_state == S_REQ);
        w_wb_vld       = (r_state == S_DONE);
        w_misalign_out = (r_state == S_DONE) && r_misalign;
    end

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        if (r_mem_we) begin
            case (r_size)
                2'd0: begin
                    w_wstrb = 4'b0001 << r_alu[1:0];
                    w_wdata = {4{r_sd[7:0]}};
                end
                2'd1: begin
                    w_wstrb = 4'b0011 << r_alu[1:0];
                    w_wdata = {2{r_sd[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = r_sd;
                end
            endcase
        end
    end

    always_comb begin
        w_ld_byte = data_sram_rdata[{r_alu[1:0], 3'b000} +: 8];
        w_ld_half = data_sram_rdata[{r_alu[1], 4'b0000} +: 16];
        case (r_size)
            2'd0:    w_ld_ext = r_uns ? {24'h0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
            2'd1:    w_ld_ext = r_uns ? {16'h0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
            default: w_ld_ext = data_sram_rdata;
        endcase
    end

    // Stores and misaligned accesses never write the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= 32'h0;
            r_alu      <= 32'h0;
            r_sd       <= 32'h0;
            r_rd       <= 5'h0;
            r_reg_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_size     <= 2'd0;
            r_uns      <= 1'b0;
            r_misalign <= 1'b0;
            r_wb_wdata <= 32'h0;
        end else if (w_accept) begin
            r_pc       <= w_ex.pc;
            r_alu      <= w_ex.alu;
            r_sd       <= w_ex.sd;
            r_rd       <= w_ex.rd;
            r_reg_we   <= w_ex.reg_we & ~w_ex.mem_we & ~w_in_misalign;
            r_mem_re   <= w_ex.mem_re;
            r_mem_we   <= w_ex.mem_we;
            r_size     <= w_ex.size;
            r_uns      <= w_ex.uns;
            r_misalign <= w_in_misalign;
            r_wb_wdata <= w_in_misalign ? 32'h0 : w_ex.alu;
        end else if ((r_state == S_WAIT) && data_sram_data_ok && r_mem_re) begin
            r_wb_wdata <= w_ld_ext;
        end
    end

    assign ex_mem_reg_allow_in = w_allow_in;
    assign data_sram_req       = w_req;
    assign data_sram_wr        = r_mem_we;
    assign data_sram_size      = r_size;
    assign data_sram_wstrb     = w_wstrb;
    assign data_sram_addr      = r_alu;
    assign data_sram_wdata     = w_wdata;
    assign mem_to_wb_reg_valid = w_wb_vld;
    assign mem_data            = {r_pc, r_wb_wdata, r_rd, r_reg_we};
    assign mem_misalign        = w_misalign_out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU, loads, stores, misalign, backpressure, reset mid-transaction.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         ex_to_mem_reg_valid;
    logic [106:0] ex_data;
    logic         ex_mem_reg_allow_in;
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [1:0]   data_sram_size;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         mem_wb_reg_allow_in;
    logic         mem_to_wb_reg_valid;
    logic [69:0]  mem_data;
    logic         mem_misalign;

    int n_checks;
    int n_errors;

    mem_stage #(.EX_W(107), .MEM_W(70)) dut (
        .clk                 (clk),
        .reset               (reset),
        .ex_to_mem_reg_valid (ex_to_mem_reg_valid),
        .ex_data             (ex_data),
        .ex_mem_reg_allow_in (ex_mem_reg_allow_in),
        .data_sram_req       (data_sram_req),
        .data_sram_wr        (data_sram_wr),
        .data_sram_size      (data_sram_size),
        .data_sram_wstrb     (data_sram_wstrb),
        .data_sram_addr      (data_sram_addr),
        .data_sram_wdata     (data_sram_wdata),
        .data_sram_addr_ok   (data_sram_addr_ok),
        .data_sram_data_ok   (data_sram_data_ok),
        .data_sram_rdata     (data_sram_rdata),
        .mem_wb_reg_allow_in (mem_wb_reg_allow_in),
        .mem_to_wb_reg_valid (mem_to_wb_reg_valid),
        .mem_data            (mem_data),
        .mem_misalign        (mem_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [106:0] pack(input logic [31:0] pc, input logic [31:0] alu,
                                          input logic [31:0] sd, input logic [4:0] rd,
                                          input logic we, input logic re, input logic mwe,
                                          input logic [1:0] size, input logic uns);
        return {pc, alu, sd, rd, we, re, mwe, size, uns};
    endfunction

    function automatic logic [69:0] md(input logic [31:0] pc, input logic [31:0] wb,
                                       input logic [4:0] rd, input logic we);
        return {pc, wb, rd, we};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One SRAM access with a single-cycle stall on addr_ok.
    task automatic do_mem(input string tag, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] rd, input logic re,
                          input logic mwe, input logic [1:0] size, input logic uns,
                          input logic [31:0] rdata, input logic [3:0] exp_wstrb,
                          input logic [31:0] exp_wdata, input logic [69:0] exp_md);
        ex_to_mem_reg_valid = 1'b1;
        ex_data = pack(pc, alu, sd, rd, 1'b1, re, mwe, size, uns);
        tick();
        ex_to_mem_reg_valid = 1'b0;
        check({tag, ".req"}, data_sram_req, 1'b1);
        check({tag, ".wr"}, data_sram_wr, mwe);
        check({tag, ".addr"}, data_sram_addr, alu);
        check({tag, ".size"}, data_sram_size, size);
        check({tag, ".wstrb"}, data_sram_wstrb, exp_wstrb);
        if (mwe) check({tag, ".wdata"}, data_sram_wdata, exp_wdata);
        check({tag, ".allow_req"}, ex_mem_reg_allow_in, 1'b0);
        tick();
        check({tag, ".req_held"}, data_sram_req, 1'b1);
        check({tag, ".addr_held"}, data_sram_addr, alu);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        check({tag, ".req_wait"}, data_sram_req, 1'b0);
        check({tag, ".vld_wait"}, mem_to_wb_reg_valid, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        check({tag, ".vld"}, mem_to_wb_reg_valid, 1'b1);
        check({tag, ".mem_data"}, mem_data, exp_md);
        tick();
        check({tag, ".idle"}, mem_to_wb_reg_valid, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        ex_to_mem_reg_valid = 1'b0;
        ex_data = '0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        mem_wb_reg_allow_in = 1'b1;
        #3;
        check("rst.allow", ex_mem_reg_allow_in, 1'b1);
        check("rst.req", data_sram_req, 1'b0);
        check("rst.vld", mem_to_wb_reg_valid, 1'b0);
        check("rst.mem_data", mem_data, 70'h0);
        check("rst.misalign", mem_misalign, 1'b0);
        check("rst.wstrb", data_sram_wstrb, 4'h0);
        tick();
        tick();
        reset = 1'b1;

        // ALU back-to-back
        ex_to_mem_reg_valid = 1'b1;
        ex_data = pack(32'h80, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        #1;
        check("alu.allow_idle", ex_mem_reg_allow_in, 1'b1);
        tick();
        check("alu1.vld", mem_to_wb_reg_valid, 1'b1);
        check("alu1.mem_data", mem_data, md(32'h80, 32'h1234, 5'd5, 1'b1));
        check("alu1.req", data_sram_req, 1'b0);
        check("alu1.allow", ex_mem_reg_allow_in, 1'b1);
        ex_data = pack(32'h84, 32'h5678, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        tick();
        ex_to_mem_reg_valid = 1'b0;
        check("alu2.vld", mem_to_wb_reg_valid, 1'b1);
        check("alu2.mem_data", mem_data, md(32'h84, 32'h5678, 5'd6, 1'b1));
        tick();
        check("alu2.idle", mem_to_wb_reg_valid, 1'b0);

        // Loads
        do_mem("lb_s", 32'h100, 32'h1003, 32'h0, 5'd7, 1'b1, 1'b0, 2'd0, 1'b0,
               32'h80FF_0000, 4'h0, 32'h0, md(32'h100, 32'hFFFF_FF80, 5'd7, 1'b1));
        do_mem("lb_u", 32'h104, 32'h1003, 32'h0, 5'd7, 1'b1, 1'b0, 2'd0, 1'b1,
               32'h80FF_0000, 4'h0, 32'h0, md(32'h104, 32'h0000_0080, 5'd7, 1'b1));
        do_mem("lh_s", 32'h108, 32'h1002, 32'h0, 5'd8, 1'b1, 1'b0, 2'd1, 1'b0,
               32'h80FF_0000, 4'h0, 32'h0, md(32'h108, 32'hFFFF_80FF, 5'd8, 1'b1));
        do_mem("lw", 32'h10C, 32'h1004, 32'h0, 5'd9, 1'b1, 1'b0, 2'd2, 1'b0,
               32'hCAFE_F00D, 4'h0, 32'h0, md(32'h10C, 32'hCAFE_F00D, 5'd9, 1'b1));

        // Stores
        do_mem("sh", 32'h200, 32'h2002, 32'hABCD_1234, 5'd3, 1'b0, 1'b1, 2'd1, 1'b0,
               32'h0, 4'b1100, 32'h1234_1234, md(32'h200, 32'h2002, 5'd3, 1'b0));
        do_mem("sb", 32'h204, 32'h2001, 32'h1122_33AB, 5'd4, 1'b0, 1'b1, 2'd0, 1'b0,
               32'h0, 4'b0010, 32'hABAB_ABAB, md(32'h204, 32'h2001, 5'd4, 1'b0));
        do_mem("sw", 32'h208, 32'h2004, 32'h8765_4321, 5'd4, 1'b0, 1'b1, 2'd2, 1'b0,
               32'h0, 4'b1111, 32'h8765_4321, md(32'h208, 32'h2004, 5'd4, 1'b0));

        // Misaligned word load, then an ALU op follows without a bubble
        ex_to_mem_reg_valid = 1'b1;
        ex_data = pack(32'h300, 32'h3001, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        ex_data = pack(32'h304, 32'h55, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        check("mis.req", data_sram_req, 1'b0);
        check("mis.flag", mem_misalign, 1'b1);
        check("mis.vld", mem_to_wb_reg_valid, 1'b1);
        check("mis.mem_data", mem_data, md(32'h300, 32'h0, 5'd9, 1'b0));
        tick();
        ex_to_mem_reg_valid = 1'b0;
        check("mis_next.flag", mem_misalign, 1'b0);
        check("mis_next.mem_data", mem_data, md(32'h304, 32'h55, 5'd10, 1'b1));
        tick();
        check("mis_next.idle", mem_to_wb_reg_valid, 1'b0);

        // Backpressure in DONE
        mem_wb_reg_allow_in = 1'b0;
        ex_to_mem_reg_valid = 1'b1;
        ex_data = pack(32'h400, 32'hAAAA, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        tick();
        ex_data = pack(32'h404, 32'hBBBB, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        #1;
        check("bp.allow", ex_mem_reg_allow_in, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp.vld", mem_to_wb_reg_valid, 1'b1);
            check("bp.hold", mem_data, md(32'h400, 32'hAAAA, 5'd11, 1'b1));
            check("bp.allow_hold", ex_mem_reg_allow_in, 1'b0);
        end
        mem_wb_reg_allow_in = 1'b1;
        #1;
        check("bp.allow_rel", ex_mem_reg_allow_in, 1'b1);
        tick();
        ex_to_mem_reg_valid = 1'b0;
        check("bp.next", mem_data, md(32'h404, 32'hBBBB, 5'd12, 1'b1));
        check("bp.next_vld", mem_to_wb_reg_valid, 1'b1);
        tick();
        check("bp.idle", mem_to_wb_reg_valid, 1'b0);

        // Reset asserted while waiting for data_ok
        ex_to_mem_reg_valid = 1'b1;
        ex_data = pack(32'h500, 32'h4000, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        ex_to_mem_reg_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        check("rw.wait_req", data_sram_req, 1'b0);
        check("rw.wait_allow", ex_mem_reg_allow_in, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("rw.allow", ex_mem_reg_allow_in, 1'b1);
        check("rw.req", data_sram_req, 1'b0);
        check("rw.vld", mem_to_wb_reg_valid, 1'b0);
        check("rw.mem_data", mem_data, 70'h0);
        check("rw.addr", data_sram_addr, 32'h0);
        tick();
        reset = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hDEAD_BEEF;
        tick();
        data_sram_data_ok = 1'b0;
        check("rw.late_vld", mem_to_wb_reg_valid, 1'b0);
        check("rw.late_allow", ex_mem_reg_allow_in, 1'b1);
        check("rw.late_req", data_sram_req, 1'b0);
        tick();
        check("rw.idle_vld", mem_to_wb_reg_valid, 1'b0);
        check("rw.idle_data", mem_data, 70'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
